halt_dump_ctrl: RTL

- On-chip end-of-run controller for the pipelined RISC-V core. It watches writeback-stage commits (pcW).
- When a commit reaches the halt PC, or the cycle budget runs out, it freezes the core. It then walks the register file through a spare read port.
- The snapshot goes out as a valid/ready word stream: halt PC, x0..x31, cycle count. A bench or UART bridge consumes this stream in place of hierarchical register peeking.

---
 rtl/halt_dump_ctrl_pkg.sv | 19 +
 rtl/halt_dump_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/halt_dump_ctrl_pkg.sv
// Shared encodings for the end-of-run halt/dump controller: FSM states,
// stream word indices and the default halt PC.
package halt_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        HDR  = 3'd1,
        REGS = 3'd2,
        CNT  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int          DUMP_WORDS      = 34;
    localparam logic [5:0]  IDX_PC          = 6'd0;
    localparam logic [5:0]  IDX_X0          = 6'd1;
    localparam logic [5:0]  IDX_CNT         = 6'(DUMP_WORDS - 1);
    localparam logic [31:0] DEFAULT_HALT_PC = 32'h0000_0048;

endpackage

// File: rtl/halt_dump_ctrl.sv
// End-of-run controller: freezes the core on a halt PC commit or cycle budget
// expiry, then streams halt PC, x0..x31 and the cycle count over valid/ready.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | core running, cycle counter advancing, watching commits
// HDR   | core frozen, presenting the latched halt PC (idx 0)
// REGS  | walking x0..x31 through the debug read port (idx 1..32)
// CNT   | presenting the frozen cycle count (idx 33, last beat)
// DONE  | stream complete, core stays frozen until reset
module halt_dump_ctrl
    import halt_dump_ctrl_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] HALT_PC    = XLEN'(DEFAULT_HALT_PC),
    parameter int              MAX_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] pcW,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            cpu_freeze,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic [5:0]      dump_idx,
    output logic            dump_last,
    output logic            halted,
    output logic            timeout,
    output logic            done
);

    localparam logic [XLEN-1:0] TMO_CNT = XLEN'(MAX_CYCLES - 1);
    localparam logic [XLEN-1:0] CNT_MAX = '1;

    state_t          state;
    logic [XLEN-1:0] cycle_cnt;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] halt_pc_q;
    logic            halt_evt;
    logic            tmo_evt;
    logic            xfer;

    assign halt_evt = wb_valid && (pcW == HALT_PC);
    assign tmo_evt  = (cycle_cnt == TMO_CNT);
    assign xfer     = dump_valid && dump_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cycle_cnt  <= '0;
            last_pc    <= '0;
            halt_pc_q  <= '0;
            rf_raddr   <= '0;
            cpu_freeze <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (wb_valid)
                        last_pc <= pcW;
                    if (halt_evt || tmo_evt) begin
                        // A commit in the event cycle is the most recent one, halting or not.
                        state      <= HDR;
                        halt_pc_q  <= wb_valid ? pcW : last_pc;
                        cpu_freeze <= 1'b1;
                        halted     <= 1'b1;
                        timeout    <= !halt_evt;
                        dump_valid <= 1'b1;
                        dump_idx   <= IDX_PC;
                    end else if (cycle_cnt != CNT_MAX) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state    <= REGS;
                        rf_raddr <= '0;
                        dump_idx <= IDX_X0;
                    end
                end
                REGS: begin
                    if (xfer) begin
                        if (rf_raddr == 5'd31) begin
                            state     <= CNT;
                            dump_idx  <= IDX_CNT;
                            dump_last <= 1'b1;
                        end else begin
                            rf_raddr <= rf_raddr + 5'd1;
                            dump_idx <= dump_idx + 6'd1;
                        end
                    end
                end
                CNT: begin
                    if (xfer) begin
                        state      <= DONE;
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= RUN;
            endcase
        end
    end

    // Register words come straight off the read port; the frozen core keeps them stable.
    always_comb begin
        dump_data = '0;
        case (state)
            HDR:  dump_data = halt_pc_q;
            REGS: if (rf_raddr != 5'd0) dump_data = rf_rdata;
            CNT:  dump_data = cycle_cnt;
            default: dump_data = '0;
        endcase
    end

endmodule
